// File: rtl/spi_byte_engine.sv
// SPI mode-0 master byte engine: pulls bytes from the TX splitter, shifts them
// MSB-first on MOSI and hands each received MISO byte to the RX combiner.
module spi_byte_engine #(
   parameter int unsigned HALF_DIV = 2500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_empty,
   output logic       tx_rden,
   output logic [7:0] rx_data,
   output logic       rx_wren,
   input  logic       rx_full,
   output logic       rx_overflow,
   output logic       cs_l,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       idle
);

   localparam int unsigned CNT_W = $clog2(HALF_DIV + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_XFER  = 3'd2,
      S_TAIL  = 3'd3,
      S_GUARD = 3'd4
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         bit_cnt_q;
   logic [7:0]         shift_tx_q;
   logic [6:0]         shift_rx_q;
   logic               miso_meta_q;
   logic               miso_s_q;
   logic               cs_l_q;
   logic               sclk_q;
   logic               mosi_q;
   logic               tx_rden_q;
   logic               rx_wren_q;
   logic               rx_ovf_q;
   logic [7:0]         rx_data_q;

   logic               term_c;
   logic [7:0]         rx_next_c;
   logic [CNT_W-1:0]   cnt_inc_c;

   assign term_c    = (cnt_q == CNT_W'(HALF_DIV - 1));
   assign cnt_inc_c = cnt_q + CNT_W'(1);
   // Byte as it stands once the bit sampled at the end of the high phase lands
   assign rx_next_c = {shift_rx_q, miso_s_q};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         shift_tx_q  <= '0;
         shift_rx_q  <= '0;
         miso_meta_q <= 1'b0;
         miso_s_q    <= 1'b0;
         cs_l_q      <= 1'b1;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         tx_rden_q   <= 1'b0;
         rx_wren_q   <= 1'b0;
         rx_ovf_q    <= 1'b0;
         rx_data_q   <= '0;
      end else begin
         tx_rden_q   <= 1'b0;
         rx_wren_q   <= 1'b0;
         rx_ovf_q    <= 1'b0;
         miso_meta_q <= miso;
         miso_s_q    <= miso_meta_q;

         unique case (state_q)
            S_IDLE: begin
               if (!tx_empty) begin
                  tx_rden_q  <= 1'b1;
                  shift_tx_q <= tx_data;
                  state_q    <= S_LOAD;
               end
            end

            S_LOAD: begin
               cs_l_q    <= 1'b0;
               sclk_q    <= 1'b0;
               mosi_q    <= shift_tx_q[7];
               cnt_q     <= '0;
               bit_cnt_q <= '0;
               state_q   <= S_XFER;
            end

            S_XFER: begin
               if (!term_c) begin
                  cnt_q <= cnt_inc_c;
               end else begin
                  cnt_q  <= '0;
                  sclk_q <= ~sclk_q;
                  // Terminal count with sclk high: sample MISO and fall
                  if (sclk_q) begin
                     shift_rx_q <= rx_next_c[6:0];
                     bit_cnt_q  <= bit_cnt_q + 3'd1;
                     if (bit_cnt_q != 3'd7) begin
                        shift_tx_q <= {shift_tx_q[6:0], 1'b0};
                        mosi_q     <= shift_tx_q[6];
                     end else begin
                        if (!rx_full) begin
                           rx_wren_q <= 1'b1;
                           rx_data_q <= rx_next_c;
                        end else begin
                           rx_ovf_q <= 1'b1;
                        end
                        // Chain straight into the next byte while CS stays low
                        if (!tx_empty) begin
                           tx_rden_q  <= 1'b1;
                           shift_tx_q <= tx_data;
                           mosi_q     <= tx_data[7];
                           bit_cnt_q  <= '0;
                        end else begin
                           state_q <= S_TAIL;
                        end
                     end
                  end
               end
            end

            S_TAIL: begin
               if (!term_c) begin
                  cnt_q <= cnt_inc_c;
               end else begin
                  cnt_q   <= '0;
                  cs_l_q  <= 1'b1;
                  mosi_q  <= 1'b0;
                  state_q <= S_GUARD;
               end
            end

            S_GUARD: begin
               if (!term_c) begin
                  cnt_q <= cnt_inc_c;
               end else begin
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign tx_rden     = tx_rden_q;
   assign rx_wren     = rx_wren_q;
   assign rx_overflow = rx_ovf_q;
   assign rx_data     = rx_data_q;
   assign cs_l        = cs_l_q;
   assign sclk        = sclk_q;
   assign mosi        = mosi_q;
   assign idle        = (state_q == S_IDLE) && tx_empty;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: TX source queue, RX scoreboard and
// event-cycle logs checked with immediate assertions.
module tb_spi_byte_engine;

   localparam int unsigned HD = 4;

   typedef struct packed {
      logic [7:0] data;
      logic       ovf;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_empty = 1'b1;
   logic       tx_rden;
   logic [7:0] rx_data;
   logic       rx_wren;
   logic       rx_full = 1'b0;
   logic       rx_overflow;
   logic       cs_l;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic       idle;

   logic       loop_en = 1'b1;
   logic       miso_fix = 1'b0;

   assign miso = loop_en ? mosi : miso_fix;

   always #5 clk = ~clk;

   spi_byte_engine #(.HALF_DIV(HD)) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_empty    (tx_empty),
      .tx_rden     (tx_rden),
      .rx_data     (rx_data),
      .rx_wren     (rx_wren),
      .rx_full     (rx_full),
      .rx_overflow (rx_overflow),
      .cs_l        (cs_l),
      .sclk        (sclk),
      .mosi        (mosi),
      .miso        (miso),
      .idle        (idle)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int sclk_bad = 0;
   int mosi_ones = 0;

   logic [7:0] txq[$];
   exp_t       sb[$];
   int rden_c[$], wren_c[$], ovf_c[$], csf_c[$], csr_c[$], rise_c[$], idle_c[$];

   logic p_sclk = 1'b0;
   logic p_cs   = 1'b1;
   logic p_idle = 1'b1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int at(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1000;
   endfunction

   task automatic drive_tx();
      tx_empty = (txq.size() == 0);
      tx_data  = (txq.size() != 0) ? txq[0] : 8'h00;
   endtask

   task automatic push_tx(input logic [7:0] b, input logic expect_rx,
                          input logic [7:0] exp_data, input logic exp_ovf);
      exp_t e;
      txq.push_back(b);
      if (expect_rx) begin
         e.data = exp_data;
         e.ovf  = exp_ovf;
         sb.push_back(e);
      end
      drive_tx();
   endtask

   task automatic clear_logs();
      rden_c.delete(); wren_c.delete(); ovf_c.delete(); csf_c.delete();
      csr_c.delete(); rise_c.delete(); idle_c.delete();
      mosi_ones = 0;
   endtask

   // One clock: sample on the falling edge, log events, pop TX, score RX
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (tx_rden) begin
         rden_c.push_back(cyc);
         if (txq.size() != 0) void'(txq.pop_front());
      end
      if (rx_wren || rx_overflow) begin
         if (rx_wren) wren_c.push_back(cyc);
         if (rx_overflow) ovf_c.push_back(cyc);
         if (sb.size() == 0) begin
            check("rx_unexpected", 32'(rx_wren), 32'(0));
            check("ovf_unexpected", 32'(rx_overflow), 32'(0));
         end else begin
            e = sb.pop_front();
            check("rx_kind", 32'({rx_wren, rx_overflow}), 32'({~e.ovf, e.ovf}));
            if (!e.ovf) check("rx_data", 32'(rx_data), 32'(e.data));
         end
      end
      if (sclk && !p_sclk) rise_c.push_back(cyc);
      if (!cs_l && p_cs) csf_c.push_back(cyc);
      if (cs_l && !p_cs) csr_c.push_back(cyc);
      if (idle && !p_idle) idle_c.push_back(cyc);
      if (cs_l && p_cs && (sclk != p_sclk)) sclk_bad++;
      if (mosi) mosi_ones++;
      p_sclk = sclk;
      p_cs   = cs_l;
      p_idle = idle;
      drive_tx();
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(idle && txq.size() == 0) && n < budget);
      if (n >= budget) check("timeout_idle", 32'(0), 32'(1));
   endtask

   initial begin
      int t;

      // Reset state
      repeat (3) tick();
      check("rst_cs_l", 32'(cs_l), 32'(1));
      check("rst_sclk", 32'(sclk), 32'(0));
      check("rst_mosi", 32'(mosi), 32'(0));
      check("rst_outs", 32'({tx_rden, rx_wren, rx_overflow}), 32'(0));
      check("rst_rx_data", 32'(rx_data), 32'(8'h00));
      check("rst_idle", 32'(idle), 32'(1));
      rst = 1'b1;
      repeat (2) tick();

      // Single byte loopback with full timing
      clear_logs();
      loop_en = 1'b1;
      push_tx(8'hA5, 1'b1, 8'hA5, 1'b0);
      wait_done(500);
      t = at(rden_c, 0);
      check("a5_rden_cnt", 32'(rden_c.size()), 32'(1));
      check("a5_cs_fall", 32'(at(csf_c, 0) - t), 32'(1));
      check("a5_first_rise", 32'(at(rise_c, 0) - t), 32'(1 + HD));
      check("a5_rise_cnt", 32'(rise_c.size()), 32'(8));
      check("a5_sclk_span", 32'(at(rise_c, 7) - at(rise_c, 0)), 32'(7 * 2 * HD));
      check("a5_wren", 32'(at(wren_c, 0) - t), 32'(1 + 16 * HD));
      check("a5_cs_rise", 32'(at(csr_c, 0) - t), 32'(1 + 17 * HD));
      check("a5_idle", 32'(at(idle_c, 0) - t), 32'(1 + 18 * HD));

      // Back-to-back pair keeps CS low
      clear_logs();
      push_tx(8'h3C, 1'b1, 8'h3C, 1'b0);
      push_tx(8'hC3, 1'b1, 8'hC3, 1'b0);
      wait_done(1000);
      check("b2b_rden_cnt", 32'(rden_c.size()), 32'(2));
      check("b2b_rden_wren", 32'(at(rden_c, 1)), 32'(at(wren_c, 0)));
      check("b2b_period", 32'(at(wren_c, 1) - at(wren_c, 0)), 32'(16 * HD));
      check("b2b_cs_fall_cnt", 32'(csf_c.size()), 32'(1));
      check("b2b_cs_rise_cnt", 32'(csr_c.size()), 32'(1));
      check("b2b_rise_cnt", 32'(rise_c.size()), 32'(16));

      // Constant MISO levels
      clear_logs();
      loop_en  = 1'b0;
      miso_fix = 1'b1;
      push_tx(8'h00, 1'b1, 8'hFF, 1'b0);
      wait_done(500);
      check("zero_mosi_ones", 32'(mosi_ones), 32'(0));
      check("zero_wren_cnt", 32'(wren_c.size()), 32'(1));
      clear_logs();
      miso_fix = 1'b0;
      push_tx(8'hFF, 1'b1, 8'h00, 1'b0);
      wait_done(500);
      check("ones_wren_cnt", 32'(wren_c.size()), 32'(1));

      // Downstream full: byte dropped
      clear_logs();
      loop_en = 1'b1;
      rx_full = 1'b1;
      push_tx(8'h5A, 1'b1, 8'h00, 1'b1);
      wait_done(500);
      rx_full = 1'b0;
      check("ovf_cnt", 32'(ovf_c.size()), 32'(1));
      check("ovf_time", 32'(at(ovf_c, 0) - at(rden_c, 0)), 32'(1 + 16 * HD));
      check("ovf_no_wren", 32'(wren_c.size()), 32'(0));
      check("ovf_rx_hold", 32'(rx_data), 32'(8'h00));

      // Reset mid-byte
      clear_logs();
      push_tx(8'hFF, 1'b0, 8'h00, 1'b0);
      begin
         int n;
         n = 0;
         while (rise_c.size() < 3 && n < 500) begin
            tick();
            n++;
         end
         if (n >= 500) check("timeout_rise", 32'(0), 32'(1));
      end
      tick();
      check("pre_rst_cs", 32'(cs_l), 32'(0));
      check("pre_rst_mosi", 32'(mosi), 32'(1));
      #2 rst = 1'b0;
      #1;
      check("arst_cs_l", 32'(cs_l), 32'(1));
      check("arst_sclk", 32'(sclk), 32'(0));
      check("arst_mosi", 32'(mosi), 32'(0));
      check("arst_wren", 32'(rx_wren), 32'(0));
      repeat (3) tick();
      rst = 1'b1;
      repeat (2) tick();
      check("arst_no_wren", 32'(wren_c.size()), 32'(0));
      clear_logs();
      push_tx(8'h81, 1'b1, 8'h81, 1'b0);
      wait_done(500);
      check("post_rst_wren_cnt", 32'(wren_c.size()), 32'(1));
      check("post_rst_wren_t", 32'(at(wren_c, 0) - at(rden_c, 0)), 32'(1 + 16 * HD));

      // TX data arrives during GUARD
      clear_logs();
      push_tx(8'h11, 1'b1, 8'h11, 1'b0);
      begin
         int n;
         n = 0;
         while (csr_c.size() == 0 && n < 500) begin
            tick();
            n++;
         end
         if (n >= 500) check("timeout_guard", 32'(0), 32'(1));
      end
      push_tx(8'h22, 1'b1, 8'h22, 1'b0);
      wait_done(1000);
      check("guard_rden_cnt", 32'(rden_c.size()), 32'(2));
      check("guard_rden_gap", 32'(at(rden_c, 1) - at(rden_c, 0)), 32'(2 + 18 * HD));
      check("guard_no_idle", 32'(at(idle_c, 0) - at(rden_c, 1)), 32'(1 + 18 * HD));

      check("sclk_while_cs_high", 32'(sclk_bad), 32'(0));
      check("sb_drained", 32'(sb.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
